sr_latch_driver: RTL and testbench

- Upstream stage for the SR latch: turns raw, asynchronous, bouncy set/reset requests into clean, mutually exclusive, fixed-width s/r drive pulses.
- Guarantees the latch never sees s=r=1. The invalid state is resolved here, reset wins.
- Pipeline: raw pins → 2-flop synchroniser → debounce counter → edge detect → pulse FSM → latch s/r.

---
 rtl/sr_latch_driver_pkg.sv | 13 +
 rtl/sr_debounce.sv | 43 ++++
 rtl/sr_latch_driver.sv | 106 ++++++++++
 tb/tb_sr_latch_driver.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/sr_latch_driver_pkg.sv
// Shared definitions for the SR latch driver: FSM encoding and default timing.
package sr_latch_driver_pkg;
  localparam int DEF_DEBOUNCE_CYCLES = 4;
  localparam int DEF_PULSE_CYCLES    = 3;
  localparam int DEF_CNT_W           = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    S_PULSE = 2'd1,
    R_PULSE = 2'd2,
    GAP     = 2'd3
  } state_e;
endpackage

// File: rtl/sr_debounce.sv
// One request channel: 2-flop synchroniser, debounce counter, rising-edge detect.
module sr_debounce
  import sr_latch_driver_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int CNT_W           = DEF_CNT_W
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_raw,
  output logic o_rise
);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             r_sync1, r_sync2;
  logic             r_deb, r_deb_prev;
  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sync1    <= 1'b0;
      r_sync2    <= 1'b0;
      r_deb      <= 1'b0;
      r_deb_prev <= 1'b0;
      r_cnt      <= '0;
    end else begin
      r_sync1    <= i_raw;
      r_sync2    <= r_sync1;
      r_deb_prev <= r_deb;
      // any agreement with the current level restarts the qualification run
      if (r_sync2 == r_deb) begin
        r_cnt <= '0;
      end else if (r_cnt == CNT_LAST) begin
        r_deb <= r_sync2;
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign o_rise = r_deb & ~r_deb_prev;
endmodule

// File: rtl/sr_latch_driver.sv
// Turns bouncy set/reset requests into exclusive fixed-width latch drive pulses;
// reset wins when both are present at the decision point.
module sr_latch_driver
  import sr_latch_driver_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int PULSE_CYCLES    = DEF_PULSE_CYCLES,
  parameter int CNT_W           = DEF_CNT_W
) (
  input  logic clk,
  input  logic rst,
  input  logic set_raw,
  input  logic reset_raw,
  output logic s_out,
  output logic r_out,
  output logic busy,
  output logic conflict
);
  localparam logic [CNT_W-1:0] PCNT_LAST = CNT_W'(PULSE_CYCLES - 1);

  logic w_rise_s, w_rise_r;
  logic w_set_req, w_rst_req;

  state_e           r_state, w_nxt_state;
  logic [CNT_W-1:0] r_pcnt, w_nxt_pcnt;
  logic             r_pend_s, r_pend_r, w_nxt_pend_s, w_nxt_pend_r;
  logic             w_nxt_conflict;
  logic             r_s_out, r_r_out, r_busy, r_conflict;

  sr_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_deb_set (
    .i_clk (clk),
    .i_rst (rst),
    .i_raw (set_raw),
    .o_rise(w_rise_s)
  );

  sr_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_deb_rst (
    .i_clk (clk),
    .i_rst (rst),
    .i_raw (reset_raw),
    .o_rise(w_rise_r)
  );

  assign w_set_req = w_rise_s | r_pend_s;
  assign w_rst_req = w_rise_r | r_pend_r;

  always_comb begin
    w_nxt_state    = r_state;
    w_nxt_pcnt     = r_pcnt;
    w_nxt_pend_s   = r_pend_s | w_rise_s;
    w_nxt_pend_r   = r_pend_r | w_rise_r;
    w_nxt_conflict = 1'b0;
    unique case (r_state)
      IDLE: begin
        w_nxt_pcnt = '0;
        if (w_rst_req) begin
          // reset served; a coincident set is discarded, not deferred
          w_nxt_state    = R_PULSE;
          w_nxt_pend_r   = 1'b0;
          w_nxt_pend_s   = 1'b0;
          w_nxt_conflict = w_set_req;
        end else if (w_set_req) begin
          w_nxt_state  = S_PULSE;
          w_nxt_pend_s = 1'b0;
        end
      end
      S_PULSE, R_PULSE: begin
        if (r_pcnt == PCNT_LAST) begin
          w_nxt_state = GAP;
          w_nxt_pcnt  = '0;
        end else begin
          w_nxt_pcnt = r_pcnt + CNT_W'(1);
        end
      end
      GAP:     w_nxt_state = IDLE;
      default: w_nxt_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_pcnt     <= '0;
      r_pend_s   <= 1'b0;
      r_pend_r   <= 1'b0;
      r_s_out    <= 1'b0;
      r_r_out    <= 1'b0;
      r_busy     <= 1'b0;
      r_conflict <= 1'b0;
    end else begin
      r_state    <= w_nxt_state;
      r_pcnt     <= w_nxt_pcnt;
      r_pend_s   <= w_nxt_pend_s;
      r_pend_r   <= w_nxt_pend_r;
      r_s_out    <= (w_nxt_state == S_PULSE);
      r_r_out    <= (w_nxt_state == R_PULSE);
      r_busy     <= (w_nxt_state != IDLE);
      r_conflict <= w_nxt_conflict;
    end
  end

  assign s_out    = r_s_out;
  assign r_out    = r_r_out;
  assign busy     = r_busy;
  assign conflict = r_conflict;
endmodule

// File: tb/tb_sr_latch_driver.sv
// Bench for sr_latch_driver: window-based reference model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_sr_latch_driver;
  import sr_latch_driver_pkg::*;

  localparam int DEB = DEF_DEBOUNCE_CYCLES;
  localparam int PUL = DEF_PULSE_CYCLES;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic set_raw = 1'b0;
  logic reset_raw = 1'b0;
  logic s_out, r_out, busy, conflict;

  always #5 clk = ~clk;

  sr_latch_driver #(.DEBOUNCE_CYCLES(DEB), .PULSE_CYCLES(PUL), .CNT_W(DEF_CNT_W)) dut (
    .clk      (clk),
    .rst      (rst),
    .set_raw  (set_raw),
    .reset_raw(reset_raw),
    .s_out    (s_out),
    .r_out    (r_out),
    .busy     (busy),
    .conflict (conflict)
  );

  int n_vec = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0d want %0d (t=%0t)", nm, got, want, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Channel 0 = set, 1 = reset. The synchronised sample seen at edge t is the
  // raw level from edge t-2 (zero if reset hit either of those edges); the
  // debounced level flips when the last DEB synchronised samples all disagree.
  bit raw_h1 [2], raw_h2 [2];
  bit rst_h1, rst_h2;
  bit win [2][DEB];
  bit deb_now [2], deb_old [2];
  bit pend [2];
  int bl;          // cycles left in pulse+gap, 0 when idle
  bit kind_r;
  bit m_conf;

  always @(posedge clk) begin
    bit rise [2];
    bit cur_raw [2];
    bit s_t, all_diff, nd, sreq, rreq;
    cur_raw[0] = set_raw;
    cur_raw[1] = reset_raw;
    for (int c = 0; c < 2; c++) rise[c] = deb_now[c] & ~deb_old[c];

    if (rst) begin
      bl = 0; pend[0] = 0; pend[1] = 0; m_conf = 0;
    end else begin
      m_conf = 0;
      if (bl > 0) begin
        pend[0] = pend[0] | rise[0];
        pend[1] = pend[1] | rise[1];
        bl--;
      end else begin
        sreq = rise[0] | pend[0];
        rreq = rise[1] | pend[1];
        if (rreq) begin
          kind_r = 1; bl = PUL + 1; m_conf = sreq; pend[0] = 0; pend[1] = 0;
        end else if (sreq) begin
          kind_r = 0; bl = PUL + 1; pend[0] = 0;
        end
      end
    end

    for (int c = 0; c < 2; c++) begin
      s_t = (rst_h1 | rst_h2) ? 1'b0 : raw_h2[c];
      for (int k = DEB - 1; k > 0; k--) win[c][k] = win[c][k-1];
      win[c][0] = s_t;
      all_diff = 1;
      for (int k = 0; k < DEB; k++) if (win[c][k] == deb_now[c]) all_diff = 0;
      nd = rst ? 1'b0 : (all_diff ? ~deb_now[c] : deb_now[c]);
      deb_old[c] = rst ? 1'b0 : deb_now[c];
      deb_now[c] = nd;
      raw_h2[c] = raw_h1[c];
      raw_h1[c] = cur_raw[c];
    end
    rst_h2 = rst_h1;
    rst_h1 = rst;
  end

  // ---------------- compare process ----------------
  int run_s = 0, run_r = 0;
  bit prev_s = 0, prev_r = 0;

  always @(negedge clk) begin
    if (chk_en) begin
      chk("s_out",    s_out,    (bl > 1) && !kind_r);
      chk("r_out",    r_out,    (bl > 1) && kind_r);
      chk("busy",     busy,     bl > 0);
      chk("conflict", conflict, m_conf);
      chk("excl",     s_out & r_out, 0);
      if (rst) begin
        run_s = 0; run_r = 0;
      end else begin
        if (s_out) run_s++;
        else if (run_s > 0) begin chk("s_width", run_s, PUL); run_s = 0; end
        if (r_out) run_r++;
        else if (run_r > 0) begin chk("r_width", run_r, PUL); run_r = 0; end
        chk("gap", (s_out && prev_r) || (r_out && prev_s), 0);
      end
      prev_s = s_out;
      prev_r = r_out;
    end
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // ---------------- stimulus ----------------
  int ns, nr, nc;
  int hold [2];
  bit val [2];

  initial begin
    rst = 1; set_raw = 0; reset_raw = 0;
    tick();
    chk_en = 1;
    tick();
    chk("rst_s", s_out, 0); chk("rst_r", r_out, 0);
    chk("rst_busy", busy, 0); chk("rst_conf", conflict, 0);

    // set held: pulse on edges 7..9, gap on 10
    rst = 0; set_raw = 1;
    for (int k = 1; k <= 12; k++) begin
      tick();
      chk("p1_s", s_out, (k >= 7 && k <= 9));
      chk("p1_busy", busy, (k >= 7 && k <= 10));
      chk("p1_r", r_out, 0);
    end
    set_raw = 0;
    repeat (12) tick();

    // glitch shorter than the debounce window
    set_raw = 1;
    repeat (3) tick();
    set_raw = 0;
    for (int k = 0; k < 15; k++) begin
      tick();
      chk("p2_busy", busy, 0);
    end

    // simultaneous rise: reset wins, conflict once
    ns = 0; nr = 0; nc = 0;
    set_raw = 1; reset_raw = 1;
    for (int k = 1; k <= 14; k++) begin
      tick();
      ns += s_out; nr += r_out; nc += conflict;
      if (k == 7) chk("p3_conf_edge", conflict, 1);
    end
    chk("p3_s_cnt", ns, 0); chk("p3_r_cnt", nr, PUL); chk("p3_conf_cnt", nc, 1);
    set_raw = 0; reset_raw = 0;
    repeat (14) tick();

    // reset arrives during S_PULSE: queued, served after gap
    ns = 0; nr = 0; nc = 0;
    set_raw = 1;
    tick();
    ns += s_out; nr += r_out; nc += conflict;
    reset_raw = 1;
    for (int k = 2; k <= 20; k++) begin
      tick();
      ns += s_out; nr += r_out; nc += conflict;
      if (k == 11) chk("p4_r_idle", r_out, 0);
      if (k == 12) chk("p4_r_start", r_out, 1);
    end
    chk("p4_s_cnt", ns, PUL); chk("p4_r_cnt", nr, PUL); chk("p4_conf_cnt", nc, 0);
    set_raw = 0; reset_raw = 0;
    repeat (14) tick();

    // rst mid R_PULSE aborts; held request re-qualifies from scratch
    reset_raw = 1;
    for (int k = 1; k <= 7; k++) tick();
    chk("p5_r_on", r_out, 1);
    rst = 1;
    tick();
    chk("p5_abort_r", r_out, 0); chk("p5_abort_busy", busy, 0);
    rst = 0;
    for (int j = 1; j <= 8; j++) begin
      tick();
      chk("p5_refire", r_out, (8 + j >= 15));
    end
    reset_raw = 0;
    repeat (20) tick();

    // random bouncy traffic with occasional reset
    hold[0] = 0; hold[1] = 0; val[0] = 0; val[1] = 0;
    for (int i = 0; i < 10000; i++) begin
      for (int c = 0; c < 2; c++) begin
        if (hold[c] == 0) begin
          val[c] = 1'($urandom_range(0, 1));
          hold[c] = ($urandom_range(0, 3) == 0) ? $urandom_range(6, 20) : $urandom_range(1, 4);
        end
        hold[c]--;
      end
      set_raw = val[0];
      reset_raw = val[1];
      rst = ($urandom_range(0, 499) == 0);
      tick();
    end
    rst = 0; set_raw = 0; reset_raw = 0;
    repeat (20) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
